multiplexor_arbitro: RTL
========================

# multiplexor_arbitro

Collects words from up to 2**N−1 sources onto one shared output channel. Each source offers a word in its own ANCHO-wide slot of a concatenated input bus. The block arbitrates between the sources, registers the winning word, and holds it until the consumer accepts it. It is the gathering counterpart of the team's demultiplexor: same slot packing, same valid-bit convention, and index 0 reserved as "no source".

## Interface
- ANCHO, default 9 — word width; bit ANCHO−1 is the valid/request flag, bits ANCHO−2:0 are data.
- N, default 2 — select width; 2**N slots, slot 0 reserved and never granted.
- clk  input  1 — sole clock, rising edge.
- rst_n  input  1 — asynchronous, active-low reset.
- Entradas  input  (2**N)*ANCHO — concatenated source slots {slot 2**N−1, …, slot 1, slot 0}; slot i is Entradas[ANCHO*i +: ANCHO]; slot 0 is ignored.
- Listo  input  1 — consumer ready; a transfer completes on a rising edge where Salida[ANCHO−1]=1 and Listo=1.
- Salida  output  ANCHO — registered granted word; bit ANCHO−1=1 means the word is valid.
- SEL  output  N — index of the source currently held in Salida; 0 when idle.
- Ack  output  2**N — one-hot, one-cycle capture pulse to the granted source; bit 0 is always 0.

## Operation
- Request: source i (1 ≤ i ≤ 2**N−1) requests when Entradas[ANCHO*i+ANCHO−1]=1.
- FSM states:
  - LIBRE (reset state): outputs cleared. On an edge where any request is present, capture the winner's full slot into Salida, set SEL to the winner, set Ack[winner]=1, and go to OCUPADO. With no request, stay in LIBRE.
  - OCUPADO: Salida and SEL are held stable and all requests are ignored. On an edge with Listo=1, clear Salida and SEL to 0 and go to LIBRE. With Listo=0, stay in OCUPADO indefinitely.
- Ack is high only in the cycle immediately after the capture edge; all other cycles it is 0.
- Source contract: after seeing Ack, a source presents its next word or drops its request by the following edge. The mandatory LIBRE cycle guarantees the same word is never captured twice.
- Arbitration order: see Configuration. Index 0 is never a candidate.
- Pointer Ultimo (N bits) holds the last granted index. It updates only at capture edges and resets to 2**N−1, so source 1 has first priority after reset.
- Slot contents other than the valid bit are don't-care while that slot is not requesting.

## Timing
- Reset values: Salida=0, SEL=0, Ack=0, state LIBRE, Ultimo=2**N−1.
- Reset is asynchronous. Asserting rst_n mid-transfer clears all outputs immediately; the held word is dropped and no Ack is issued.
- Latency: a request present before edge k appears in Salida/SEL after edge k, with Ack pulsing during cycle k→k+1.
- Minimum transfer period is 2 cycles (capture edge, then accept edge). Peak throughput is 1 word per 2 clocks, reached when Listo is tied high.
- Listo=1 during LIBRE has no effect.
- A request that drops while the block is in OCUPADO is simply not seen; no state is kept per source.
- Wrap-around: the round-robin search runs from Ultimo+1 up to 2**N−1, then from 1 up to Ultimo, skipping index 0.

## Configuration
- ARBITRO_ROUND_ROBIN_EN:
  - Defined: round-robin arbitration starting after Ultimo, as described above.
  - Undefined: fixed priority, where the lowest requesting index ≥1 wins. Ultimo is still maintained but does not affect the grant.
- The interface and timing are identical in both builds.

## Test plan
Parameters for all scenarios: N=2, ANCHO=9.
- Reset: hold rst_n=0 with all slots requesting → Salida=0, SEL=0, Ack=0. Release → first capture is source 1.
- Single source: slot 2 = 9'h1A5, Listo=1 → after the next edge Salida=9'h1A5, SEL=2, Ack=4'b0100 for one cycle. After the following edge Salida=0, SEL=0.
- Backpressure: slot 3 = 9'h1FF, Listo=0 for 5 cycles → Salida held at 9'h1FF and SEL=3 for all 5 cycles. A change on slot 1 during this time is ignored. Raising Listo releases on the next edge.
- Round-robin (macro defined): slots 1, 2 and 3 all request continuously, Listo=1 → grant sequence 1,2,3,1,2 with one LIBRE cycle between grants.
- Fixed priority (macro undefined): same stimulus as the round-robin case → grant sequence 1,1,1…; slot 0 with its valid bit set is never granted.
- Mid-transfer reset: pull rst_n low while in OCUPADO with SEL=2 → Salida, SEL and Ack go to 0 without waiting for a clock edge. After release, source 1 is granted first.

Source files
------------

// File: rtl/multiplexor_arbitro.sv
// -----------------------------------------------------------------------------
// multiplexor_arbitro
//
// Gathers words from up to 2**N-1 sources onto one shared output channel.
// Each source owns an ANCHO-wide slot of the concatenated Entradas bus. The
// MSB of every slot is its valid/request flag. Slot 0 is reserved as
// "no source" and is never granted. The winning word is registered into
// Salida and held until the consumer accepts it with Listo.
//
// Optional feature (compile-time macro):
//   ARBITRO_ROUND_ROBIN_EN  defined   -> round-robin grant starting after the
//                                        last granted index (Ultimo).
//                           undefined -> fixed priority: the lowest requesting
//                                        index >= 1 wins. Ultimo is still
//                                        tracked but does not affect the grant.
//
// Handshake: a transfer completes on a rising edge where Salida[ANCHO-1]=1 and
// Listo=1. A capture is signalled to the winning source by a one-cycle,
// one-hot pulse on Ack in the cycle that follows the capture edge. After Ack
// the source must present its next word or drop its request by the next
// edge. The mandatory LIBRE cycle between grants prevents a double capture.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   Entradas  in   {slot 2**N-1, ..., slot 1, slot 0}, ANCHO bits per slot
//   Listo     in   consumer ready
//   Salida    out  registered granted word (MSB = valid)
//   SEL       out  index of the source held in Salida, 0 when idle
//   Ack       out  one-hot capture pulse to the granted source (bit 0 never set)
//
// Debug: the FSM state is held in estado_q (type estado_t) so that checkers
// can bind to it hierarchically.
// -----------------------------------------------------------------------------
module multiplexor_arbitro #(
    parameter int ANCHO = 9,
    parameter int N     = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [(2**N)*ANCHO-1:0]   Entradas,
    input  logic                      Listo,
    output logic [ANCHO-1:0]          Salida,
    output logic [N-1:0]              SEL,
    output logic [(2**N)-1:0]         Ack
);

    localparam int NUM_SLOTS = 2**N;

    typedef enum logic {
        LIBRE   = 1'b0,
        OCUPADO = 1'b1
    } estado_t;

    estado_t              estado_q, estado_d;
    logic [ANCHO-1:0]     salida_q, salida_d;
    logic [N-1:0]         sel_q, sel_d;
    logic [NUM_SLOTS-1:0] ack_q, ack_d;
    logic [N-1:0]         ultimo_q, ultimo_d;

    logic [ANCHO-1:0]     slot [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] req;
    logic                 hay_req;
    logic [N-1:0]         ganador;

    // Unpack the slots; index 0 never raises a request.
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot[i] = Entradas[ANCHO*i +: ANCHO];
        end
        for (int i = 1; i < NUM_SLOTS; i++) begin
            req[i] = slot[i][ANCHO-1];
        end
    end

    assign hay_req = |req;

`ifdef ARBITRO_ROUND_ROBIN_EN
    // Round-robin: prefer the lowest requester above Ultimo; if there is none,
    // wrap around to the lowest requester overall (indices 1..Ultimo).
    // The loops run downwards so the last hit is the lowest index.
    logic         hay_alto;
    logic [N-1:0] gan_alto;
    logic [N-1:0] gan_bajo;

    always_comb begin
        hay_alto = 1'b0;
        gan_alto = '0;
        gan_bajo = '0;
        for (int i = NUM_SLOTS-1; i >= 1; i--) begin
            if (req[i]) begin
                gan_bajo = N'(i);
                if (i > int'(ultimo_q)) begin
                    gan_alto = N'(i);
                    hay_alto = 1'b1;
                end
            end
        end
        ganador = hay_alto ? gan_alto : gan_bajo;
    end
`else
    // Fixed priority: lowest requesting index >= 1 wins.
    always_comb begin
        ganador = '0;
        for (int i = NUM_SLOTS-1; i >= 1; i--) begin
            if (req[i]) begin
                ganador = N'(i);
            end
        end
    end
`endif

    // State register (all flops).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= LIBRE;
            salida_q <= '0;
            sel_q    <= '0;
            ack_q    <= '0;
            ultimo_q <= '1;
        end else begin
            estado_q <= estado_d;
            salida_q <= salida_d;
            sel_q    <= sel_d;
            ack_q    <= ack_d;
            ultimo_q <= ultimo_d;
        end
    end

    // Next-state logic.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            LIBRE:   if (hay_req) estado_d = OCUPADO;
            OCUPADO: if (Listo)   estado_d = LIBRE;
        endcase
    end

    // Output / datapath logic. Ack defaults to 0 so it pulses for exactly one
    // cycle after a capture edge.
    always_comb begin
        salida_d = salida_q;
        sel_d    = sel_q;
        ack_d    = '0;
        ultimo_d = ultimo_q;
        case (estado_q)
            LIBRE: begin
                if (hay_req) begin
                    salida_d       = slot[ganador];
                    sel_d          = ganador;
                    ack_d[ganador] = 1'b1;
                    ultimo_d       = ganador;
                end else begin
                    salida_d = '0;
                    sel_d    = '0;
                end
            end
            OCUPADO: begin
                // Requests are ignored while a word is held.
                if (Listo) begin
                    salida_d = '0;
                    sel_d    = '0;
                end
            end
        endcase
    end

    assign Salida = salida_q;
    assign SEL    = sel_q;
    assign Ack    = ack_q;

endmodule
